moment_calc_unit: RTL
=====================

// Module: moment_calc_unit
// PURPOSE
//  Moment stage of the D2Q9 LBM pipeline, run once the controller leaves grid initialisation.
//  Streams the 9 fin populations of every cell from fin memory and accumulates density p,
//  momentum p*ux and momentum p*uy. Writes the three sums per cell to the moment memories.
//  Pulses done so the controller can advance to the equilibrium/collision phase.
// PARAMETERS
//  DATA_WIDTH     32                    width of fin samples and moment sums (two's complement)
//  GRID_DIM       16*16                 number of lattice cells
//  ADDRESS_WIDTH  $clog2(GRID_DIM)      cell address width
//  Q              9                     populations per cell (D2Q9, fixed)
// PORTS
//  Clk         in   1              clock, all state on rising edge
//  Reset       in   1              asynchronous, active-high reset
//  start       in   1              1-cycle pulse: begin a full-grid moment pass
//  fin_cell    out  ADDRESS_WIDTH  fin read address: cell index
//  fin_dir     out  4              fin read address: direction k, 0..8
//  fin_re      out  1              fin read strobe; data returns exactly 1 cycle later
//  fin_rdata   in   DATA_WIDTH     fin sample for the address issued the previous cycle
//  mom_addr    out  ADDRESS_WIDTH  cell index for moment write
//  mom_we      out  1              write strobe for p, pux, puy memories (common)
//  p_wdata     out  DATA_WIDTH     sum_k f_k
//  pux_wdata   out  DATA_WIDTH     sum_k cx_k*f_k
//  puy_wdata   out  DATA_WIDTH     sum_k cy_k*f_k
//  busy        out  1              high from cycle after start through last write
//  done        out  1              1-cycle pulse after the final cell is written
// BEHAVIOUR
//  Reset: FSM=IDLE. All outputs 0: fin_*, mom_*, *_wdata, busy, done. Counters and accumulators 0.
//  Reset mid-pass aborts immediately. No write is issued after reset asserts.
//  FSM: IDLE -start-> RUN -last issue-> DRAIN (2 cycles) -> DONE (1 cycle) -> IDLE.
//  start is ignored in every state except IDLE.
//  RUN: one fin read per cycle, fin_re=1. dir steps 0..8, then cell+1 with dir=0.
//   After cell GRID_DIM-1 with dir 8 is issued, the FSM enters DRAIN.
//  Pipeline: a read issued at cycle t has a valid/dir/cell tag registered alongside it.
//   That tag is valid at t+1, when fin_rdata is sampled.
//   On a valid tag with dir==0, the accumulators load the contribution (no carry-over from the previous cell).
//   Otherwise the contribution is added.
//  Weights: cx = {0,1,0,-1,0,1,-1,-1,1}, cy = {0,0,1,0,-1,1,1,-1,-1} for k=0..8.
//   Implement each weight as add, subtract or hold. No multipliers.
//  Arithmetic: DATA_WIDTH-bit two's complement; overflow wraps modulo 2^DATA_WIDTH, no saturation.
//  Write: the cycle after a tagged dir==8 sample is accumulated, mom_we=1 for exactly 1 cycle.
//   On that cycle, mom_addr equals that cell and the *_wdata outputs hold the final sums.
//   The *_wdata outputs keep their values until the next write.
//  Timing (start sampled at edge 0): read of (cell n, dir k) issued in cycle 9n+k+1.
//   Cell n is written in cycle 9n+11.
//   busy is high cycles 1..9*GRID_DIM+2; done=1 in cycle 9*GRID_DIM+3, busy=0 there.
//   Throughput: one cell per 9 cycles, no bubbles between cells.
//  fin_cell and fin_dir are 0 while fin_re=0.
//  No write is produced while in IDLE or DONE.
// TESTING
//  1 all fin=1, GRID_DIM=4 -> 4 writes: p=9, pux=0, puy=0, addr 0..3 at cycles 11,20,29,38.
//    done at cycle 39.
//  2 fin[k]=k for every cell -> p=36, pux=-2 (0xFFFFFFFE), puy=-6 (0xFFFFFFFA).
//  3 fin[0]=0x7FFFFFFF, fin[1]=1, others 0 -> p=0x80000000 (wrap), pux=1, puy=0.
//  4 cell-dependent data fin=cell*16+k -> each cell's sums are independent (no leakage from the previous cell).
//    Check against a golden model.
//  5 start re-pulsed at cycle 5 of a pass -> ignored; write count and timing identical to test 1.
//  6 Reset asserted in cycle 15 (mid cell 1) -> all outputs 0 next edge; no further mom_we.
//    A new start after release gives a full clean pass.

Source files
------------

// File: rtl/moment_calc_unit.sv
// -----------------------------------------------------------------------------
// moment_calc_unit
// Moment stage of the D2Q9 LBM pipeline. Streams the 9 fin populations of
// every lattice cell and writes density p and momenta p*ux, p*uy per cell.
//
// Ports
//   Clk        in   clock, rising edge
//   Reset      in   asynchronous active-high reset
//   start      in   1-cycle pulse, starts a full-grid pass (IDLE only)
//   fin_cell   out  fin read address, cell index
//   fin_dir    out  fin read address, direction 0..8
//   fin_re     out  fin read strobe, data returns one cycle later
//   fin_rdata  in   fin sample for the previous cycle's address
//   mom_addr   out  cell index for the moment write
//   mom_we     out  common write strobe for the p/pux/puy memories
//   p_wdata    out  sum_k f_k
//   pux_wdata  out  sum_k cx_k*f_k
//   puy_wdata  out  sum_k cy_k*f_k
//   busy       out  high while a pass is in flight
//   done       out  1-cycle pulse after the final cell is written
// -----------------------------------------------------------------------------
module moment_calc_unit #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned GRID_DIM      = 16*16,
    parameter int unsigned ADDRESS_WIDTH = $clog2(GRID_DIM)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     start,
    output logic [ADDRESS_WIDTH-1:0] fin_cell,
    output logic [3:0]               fin_dir,
    output logic                     fin_re,
    input  logic [DATA_WIDTH-1:0]    fin_rdata,
    output logic [ADDRESS_WIDTH-1:0] mom_addr,
    output logic                     mom_we,
    output logic [DATA_WIDTH-1:0]    p_wdata,
    output logic [DATA_WIDTH-1:0]    pux_wdata,
    output logic [DATA_WIDTH-1:0]    puy_wdata,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned Q = 9;
    localparam logic [3:0]               LAST_DIR  = 4'(Q - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_CELL = ADDRESS_WIDTH'(GRID_DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN_0,
        S_DRAIN_1,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ADDRESS_WIDTH-1:0] r_cell;
    logic [3:0]               r_dir;
    logic                     w_last_issue;

    logic [ADDRESS_WIDTH-1:0] r_fin_cell;
    logic [3:0]               r_fin_dir;
    logic                     r_fin_re;

    logic                     r_tag_valid;
    logic [3:0]               r_tag_dir;
    logic [ADDRESS_WIDTH-1:0] r_tag_cell;

    logic [DATA_WIDTH-1:0]    r_acc_p;
    logic [DATA_WIDTH-1:0]    r_acc_pux;
    logic [DATA_WIDTH-1:0]    r_acc_puy;
    logic [DATA_WIDTH-1:0]    w_p_base;
    logic [DATA_WIDTH-1:0]    w_pux_base;
    logic [DATA_WIDTH-1:0]    w_puy_base;
    logic [DATA_WIDTH-1:0]    w_p_next;
    logic [DATA_WIDTH-1:0]    w_pux_next;
    logic [DATA_WIDTH-1:0]    w_puy_next;

    logic [ADDRESS_WIDTH-1:0] r_mom_addr;
    logic                     r_mom_we;
    logic [DATA_WIDTH-1:0]    r_p_wdata;
    logic [DATA_WIDTH-1:0]    r_pux_wdata;
    logic [DATA_WIDTH-1:0]    r_puy_wdata;
    logic                     r_busy;
    logic                     r_done;

    assign w_last_issue = (r_state == S_RUN) && (r_dir == LAST_DIR) && (r_cell == LAST_CELL);

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_next = S_RUN;
            S_RUN:     if (w_last_issue) w_state_next = S_DRAIN_0;
            S_DRAIN_0: w_state_next = S_DRAIN_1;
            S_DRAIN_1: w_state_next = S_DONE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Read address walk: dir 0..8 within a cell, then next cell
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cell <= '0;
            r_dir  <= '0;
        end else if (r_state == S_RUN) begin
            if (r_dir == LAST_DIR) begin
                r_dir  <= '0;
                r_cell <= (r_cell == LAST_CELL) ? '0 : r_cell + ADDRESS_WIDTH'(1);
            end else begin
                r_dir <= r_dir + 4'd1;
            end
        end else begin
            r_cell <= '0;
            r_dir  <= '0;
        end
    end

    // Registered read port; the address is forced to 0 when idle
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_fin_re   <= 1'b0;
            r_fin_cell <= '0;
            r_fin_dir  <= '0;
        end else begin
            r_fin_re   <= (r_state == S_RUN);
            r_fin_cell <= (r_state == S_RUN) ? r_cell : '0;
            r_fin_dir  <= (r_state == S_RUN) ? r_dir : '0;
        end
    end

    // Tag travels one cycle behind the read so it lines up with fin_rdata
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_tag_valid <= 1'b0;
            r_tag_dir   <= '0;
            r_tag_cell  <= '0;
        end else begin
            r_tag_valid <= r_fin_re;
            r_tag_dir   <= r_fin_dir;
            r_tag_cell  <= r_fin_cell;
        end
    end

    // Weighted accumulation: dir 0 restarts the sums, each weight is add/sub/hold
    always_comb begin
        w_p_base   = (r_tag_dir == 4'd0) ? '0 : r_acc_p;
        w_pux_base = (r_tag_dir == 4'd0) ? '0 : r_acc_pux;
        w_puy_base = (r_tag_dir == 4'd0) ? '0 : r_acc_puy;
        w_p_next   = w_p_base + fin_rdata;
        w_pux_next = w_pux_base;
        w_puy_next = w_puy_base;
        case (r_tag_dir)
            4'd1: w_pux_next = w_pux_base + fin_rdata;
            4'd2: w_puy_next = w_puy_base + fin_rdata;
            4'd3: w_pux_next = w_pux_base - fin_rdata;
            4'd4: w_puy_next = w_puy_base - fin_rdata;
            4'd5: begin
                w_pux_next = w_pux_base + fin_rdata;
                w_puy_next = w_puy_base + fin_rdata;
            end
            4'd6: begin
                w_pux_next = w_pux_base - fin_rdata;
                w_puy_next = w_puy_base + fin_rdata;
            end
            4'd7: begin
                w_pux_next = w_pux_base - fin_rdata;
                w_puy_next = w_puy_base - fin_rdata;
            end
            4'd8: begin
                w_pux_next = w_pux_base + fin_rdata;
                w_puy_next = w_puy_base - fin_rdata;
            end
            default: ;
        endcase
    end

    // Accumulators and moment write port; final sums are captured on the dir-8 sample
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_acc_p     <= '0;
            r_acc_pux   <= '0;
            r_acc_puy   <= '0;
            r_mom_we    <= 1'b0;
            r_mom_addr  <= '0;
            r_p_wdata   <= '0;
            r_pux_wdata <= '0;
            r_puy_wdata <= '0;
        end else begin
            r_mom_we <= r_tag_valid && (r_tag_dir == LAST_DIR);
            if (r_tag_valid) begin
                r_acc_p   <= w_p_next;
                r_acc_pux <= w_pux_next;
                r_acc_puy <= w_puy_next;
                if (r_tag_dir == LAST_DIR) begin
                    r_mom_addr  <= r_tag_cell;
                    r_p_wdata   <= w_p_next;
                    r_pux_wdata <= w_pux_next;
                    r_puy_wdata <= w_puy_next;
                end
            end
        end
    end

    // Status: busy covers RUN and DRAIN one cycle late, done follows DONE
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (r_state != S_IDLE) && (r_state != S_DONE);
            r_done <= (r_state == S_DONE);
        end
    end

    assign fin_cell  = r_fin_cell;
    assign fin_dir   = r_fin_dir;
    assign fin_re    = r_fin_re;
    assign mom_addr  = r_mom_addr;
    assign mom_we    = r_mom_we;
    assign p_wdata   = r_p_wdata;
    assign pux_wdata = r_pux_wdata;
    assign puy_wdata = r_puy_wdata;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
